// File: rtl/ui_pkg.sv
// Shared front-panel UI definitions: debouncer state encoding and the helper
// functions that size the debouncer's counters from their parameters.
package ui_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_PEND   = 2'd1,
        HELD         = 2'd2,
        RELEASE_PEND = 2'd3
    } debounce_state_t;

    // Width needed to count from 0 up to stable_samples inclusive.
    function automatic int cnt_width(input int stable_samples);
        return $clog2(stable_samples + 1);
    endfunction

    // Width of the auto-repeat hold counter: big enough for the larger interval.
    function automatic int hold_width(input int repeat_delay, input int repeat_period);
        int longest;
        longest = (repeat_delay > repeat_period) ? repeat_delay : repeat_period;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/button_debouncer_if.sv
// Signal bundle between the raw front-panel inputs and the debouncer.
// master: the debouncer (consumes raw inputs, drives the clean outputs).
// slave : the pad/consumer side (drives raw inputs, observes clean outputs).
interface button_debouncer_if;
    logic sample_clock;
    logic button_raw;
    logic pressed;
    logic press_pulse;
    logic release_pulse;

    modport master (
        input  sample_clock,
        input  button_raw,
        output pressed,
        output press_pulse,
        output release_pulse
    );

    modport slave (
        output sample_clock,
        output button_raw,
        input  pressed,
        input  press_pulse,
        input  release_pulse
    );
endinterface

// File: rtl/button_debouncer_sync_edge.sv
// Two-flop synchroniser followed by a rising-edge detector. The reset value of
// every flop is a parameter so an idle-high input does not see a false edge
// or a false level when reset is released.
module sync_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic level,
    output logic rise
);

    logic meta_r;
    logic sync_r;
    logic prev_r;

    // Synchroniser chain plus one delayed copy for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= RESET_VAL;
            sync_r <= RESET_VAL;
            prev_r <= RESET_VAL;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
            prev_r <= sync_r;
        end
    end

    assign level = sync_r;
    assign rise  = sync_r & ~prev_r;

endmodule

// File: rtl/button_debouncer.sv
// Push-button debouncer for the multiplier front panel. The raw button is
// sampled once per rising edge of the slow divider square wave; a new level is
// accepted after STABLE_SAMPLES identical samples in a row. Produces a
// debounced level plus one-cycle press/release strobes in the in_clock domain.
// Optional auto-repeat of press_pulse while held: define BUTTON_DEBOUNCER_REPEAT_EN.
module button_debouncer
    import ui_pkg::*;
#(
    parameter int STABLE_SAMPLES = 4,
    parameter int ACTIVE_LOW     = 1,
    parameter int REPEAT_DELAY   = 16,
    parameter int REPEAT_PERIOD  = 4
) (
    input  logic                in_clock,
    input  logic                reset_n,
    button_debouncer_if.master  btn_bus
);

    localparam int              CW          = cnt_width(STABLE_SAMPLES);
    localparam logic            BTN_IDLE    = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic [CW:0]     STABLE_LAST = (CW + 1)'(STABLE_SAMPLES);

    logic            tick_s;
    logic            btn_level_s;
    logic            btn_s;
    logic            sample_level_unused_s;
    logic            btn_rise_unused_s;

    debounce_state_t state_r;
    debounce_state_t state_next_s;
    logic [CW-1:0]   cnt_r;
    logic [CW-1:0]   cnt_next_s;
    logic [CW:0]     cnt_plus_s;
    logic            press_s;
    logic            release_s;
    logic            repeat_s;

    logic            pressed_r;
    logic            press_pulse_r;
    logic            release_pulse_r;

    sync_edge #(.RESET_VAL(1'b0)) u_sample_sync (
        .clk   (in_clock),
        .rst_n (reset_n),
        .d     (btn_bus.sample_clock),
        .level (sample_level_unused_s),
        .rise  (tick_s)
    );

    sync_edge #(.RESET_VAL(BTN_IDLE)) u_button_sync (
        .clk   (in_clock),
        .rst_n (reset_n),
        .d     (btn_bus.button_raw),
        .level (btn_level_s),
        .rise  (btn_rise_unused_s)
    );

    // Normalise the button so that 1 always means "held".
    assign btn_s      = (ACTIVE_LOW != 0) ? ~btn_level_s : btn_level_s;
    assign cnt_plus_s = {1'b0, cnt_r} + {{CW{1'b0}}, 1'b1};

    // State and stability-counter registers.
    always_ff @(posedge in_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= RELEASED;
            cnt_r   <= {CW{1'b0}};
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Next-state logic: evaluated only on sample ticks, otherwise everything holds.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        press_s      = 1'b0;
        release_s    = 1'b0;
        if (tick_s) begin
            case (state_r)
                RELEASED: begin
                    if (btn_s) begin
                        if (STABLE_SAMPLES == 1) begin
                            state_next_s = HELD;
                            cnt_next_s   = {CW{1'b0}};
                            press_s      = 1'b1;
                        end else begin
                            state_next_s = PRESS_PEND;
                            cnt_next_s   = CW'(1);
                        end
                    end else begin
                        cnt_next_s = {CW{1'b0}};
                    end
                end
                PRESS_PEND: begin
                    if (btn_s) begin
                        if (cnt_plus_s == STABLE_LAST) begin
                            state_next_s = HELD;
                            cnt_next_s   = {CW{1'b0}};
                            press_s      = 1'b1;
                        end else begin
                            cnt_next_s = cnt_plus_s[CW-1:0];
                        end
                    end else begin
                        state_next_s = RELEASED;
                        cnt_next_s   = {CW{1'b0}};
                    end
                end
                HELD: begin
                    if (!btn_s) begin
                        if (STABLE_SAMPLES == 1) begin
                            state_next_s = RELEASED;
                            cnt_next_s   = {CW{1'b0}};
                            release_s    = 1'b1;
                        end else begin
                            state_next_s = RELEASE_PEND;
                            cnt_next_s   = CW'(1);
                        end
                    end else begin
                        cnt_next_s = {CW{1'b0}};
                    end
                end
                RELEASE_PEND: begin
                    if (!btn_s) begin
                        if (cnt_plus_s == STABLE_LAST) begin
                            state_next_s = RELEASED;
                            cnt_next_s   = {CW{1'b0}};
                            release_s    = 1'b1;
                        end else begin
                            cnt_next_s = cnt_plus_s[CW-1:0];
                        end
                    end else begin
                        state_next_s = HELD;
                        cnt_next_s   = {CW{1'b0}};
                    end
                end
                default: begin
                    state_next_s = RELEASED;
                    cnt_next_s   = {CW{1'b0}};
                end
            endcase
        end else begin
            state_next_s = state_r;
            cnt_next_s   = cnt_r;
        end
    end

`ifdef BUTTON_DEBOUNCER_REPEAT_EN
    localparam int           HW           = hold_width(REPEAT_DELAY, REPEAT_PERIOD);
    localparam logic [HW:0]  DELAY_LAST   = (HW + 1)'(REPEAT_DELAY);
    localparam logic [HW:0]  PERIOD_LAST  = (HW + 1)'(REPEAT_PERIOD);

    logic [HW-1:0] hold_r;
    logic [HW-1:0] hold_next_s;
    logic          rep_r;
    logic          rep_next_s;
    logic [HW:0]   hold_plus_s;
    logic [HW:0]   hold_limit_s;

    assign hold_plus_s  = {1'b0, hold_r} + {{HW{1'b0}}, 1'b1};
    assign hold_limit_s = rep_r ? PERIOD_LAST : DELAY_LAST;

    // Hold counter: counts ticks spent staying in HELD, restarts on any entry.
    always_comb begin
        hold_next_s = hold_r;
        rep_next_s  = rep_r;
        repeat_s    = 1'b0;
        if ((state_r == HELD) && (state_next_s == HELD)) begin
            if (tick_s) begin
                if (hold_plus_s == hold_limit_s) begin
                    hold_next_s = {HW{1'b0}};
                    rep_next_s  = 1'b1;
                    repeat_s    = 1'b1;
                end else begin
                    hold_next_s = hold_plus_s[HW-1:0];
                end
            end else begin
                hold_next_s = hold_r;
            end
        end else begin
            hold_next_s = {HW{1'b0}};
            rep_next_s  = 1'b0;
        end
    end

    // Hold counter registers.
    always_ff @(posedge in_clock or negedge reset_n) begin
        if (!reset_n) begin
            hold_r <= {HW{1'b0}};
            rep_r  <= 1'b0;
        end else begin
            hold_r <= hold_next_s;
            rep_r  <= rep_next_s;
        end
    end
`else
    localparam int REPEAT_CFG_UNUSED = REPEAT_DELAY + REPEAT_PERIOD;
    assign repeat_s = 1'b0;
`endif

    // Registered outputs: level follows the accepted state, strobes last one cycle.
    always_ff @(posedge in_clock or negedge reset_n) begin
        if (!reset_n) begin
            pressed_r       <= 1'b0;
            press_pulse_r   <= 1'b0;
            release_pulse_r <= 1'b0;
        end else begin
            pressed_r       <= (state_next_s == HELD) || (state_next_s == RELEASE_PEND);
            press_pulse_r   <= press_s | repeat_s;
            release_pulse_r <= release_s;
        end
    end

    assign btn_bus.pressed       = pressed_r;
    assign btn_bus.press_pulse   = press_pulse_r;
    assign btn_bus.release_pulse = release_pulse_r;

endmodule
